// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit:
//     - ReqSize encodings (byte / half / word / illegal)
//     - FSM state enumeration
//     - is_misaligned(): alignment test for a size and the low address bits
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'd0;
    localparam logic [1:0] SIZE_HALF    = 2'd1;
    localparam logic [1:0] SIZE_WORD    = 2'd2;
    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WRITE,
        RESP
    } lsu_state_e;

    // Byte accesses are never misaligned; size 3 is handled as illegal elsewhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        return ((size == SIZE_HALF) && offset[0]) ||
               ((size == SIZE_WORD) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
//   Purely combinational little-endian lane steering.
//   Inputs:
//     word        - memory word as read
//     offset      - byte offset within the word (already aligned for the size)
//     size        - access size encoding
//     sign_extend - sign-extend sub-word loads (ignored for word)
//     store_data  - right-justified store data
//   Outputs:
//     load_value  - extracted and extended load result
//     merged_word - word with only the addressed lane(s) replaced by store_data
// -----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_extend,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_value;
    logic [15:0] half_value;

    assign byte_value = word[{offset, 3'b000} +: 8];
    assign half_value = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis would infer a latch.
        load_value  = word;
        merged_word = store_data;
        case (size)
            SIZE_BYTE: begin
                load_value  = {{24{sign_extend & byte_value[7]}}, byte_value};
                merged_word = word;
                merged_word[{offset, 3'b000} +: 8] = store_data[7:0];
            end
            SIZE_HALF: begin
                load_value  = {{16{sign_extend & half_value[15]}}, half_value};
                merged_word = word;
                if (offset[1]) merged_word[31:16] = store_data[15:0];
                else           merged_word[15:0]  = store_data[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   CPU-side initiator for a word-organised data memory (combinational read,
//   write on the rising edge). Handles one byte/half/word load or store at a
//   time, doing read-modify-write for sub-word stores and extract/extend for
//   sub-word loads. Each accepted request ends in a one-cycle response.
//
//   Ports:
//     Clock, Reset                 - clock, synchronous active-high reset
//     ReqValid/ReqReady            - request handshake (ready only in IDLE)
//     ReqWrite, ReqSize, ReqSigned - store flag, size encoding, sign-extend
//     ReqAddress, ReqData          - byte address, right-justified store data
//     RespValid, RespError         - one-cycle response pulse, error flag
//     RespData                     - load result, held until next response
//     MemAddress                   - word-aligned memory address
//     MemWriteData, MemWriteEnable - write word and strobe
//     MemReadData                  - combinational read of word at MemAddress
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH        = 32,
    parameter bit ERROR_ON_MISALIGN = 1'b1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [1:0]            ReqSize,
    input  logic                  ReqSigned,
    input  logic [ADDR_WIDTH-1:0] ReqAddress,
    input  logic [31:0]           ReqData,
    output logic                  RespValid,
    output logic                  RespError,
    output logic [31:0]           RespData,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic [31:0]           MemWriteData,
    output logic                  MemWriteEnable,
    input  logic [31:0]           MemReadData
);

    lsu_state_e            state;
    logic                  ready_q;
    logic                  write_enable_q;
    logic                  resp_valid_q;
    logic                  resp_error_q;
    logic [31:0]           resp_data_q;
    logic [ADDR_WIDTH-1:0] mem_address_q;
    logic [31:0]           mem_write_data_q;

    // Captured request
    logic                  write_q;
    logic                  sign_q;
    logic [1:0]            size_q;
    logic [1:0]            offset_q;
    logic [31:0]           data_q;

    logic                  accept;
    logic                  req_error;
    logic [1:0]            req_offset;
    logic [31:0]           load_value;
    logic [31:0]           merged_word;

    assign accept = ReqValid && ready_q;

    // With alignment errors disabled, the low bits below the access size are
    // simply dropped so the access proceeds on the aligned-down address.
    always_comb begin
        req_offset = ReqAddress[1:0];
        case (ReqSize)
            SIZE_HALF: req_offset = {ReqAddress[1], 1'b0};
            SIZE_WORD: req_offset = 2'b00;
            default: ;
        endcase
    end

    assign req_error = (ReqSize == SIZE_ILLEGAL) ||
                       (ERROR_ON_MISALIGN && is_misaligned(ReqSize, ReqAddress[1:0]));

    // NOTE: the captured request is only read after an accept has loaded it,
    // so these data registers carry no reset.
    always_ff @(posedge Clock) begin
        if (accept) begin
            write_q  <= ReqWrite;
            sign_q   <= ReqSigned;
            size_q   <= ReqSize;
            offset_q <= req_offset;
            data_q   <= ReqData;
        end
    end

    lsu_lane_align u_lane_align (
        .word        (MemReadData),
        .offset      (offset_q),
        .size        (size_q),
        .sign_extend (sign_q),
        .store_data  (data_q),
        .load_value  (load_value),
        .merged_word (merged_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state            <= IDLE;
            ready_q          <= 1'b0;
            write_enable_q   <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_error_q     <= 1'b0;
            resp_data_q      <= '0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
        end else begin
            resp_valid_q   <= 1'b0;
            resp_error_q   <= 1'b0;
            write_enable_q <= 1'b0;
            ready_q        <= 1'b0;
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q       <= 1'b0;
                        mem_address_q <= {ReqAddress[ADDR_WIDTH-1:2], 2'b00};
                        if (req_error) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                            resp_data_q  <= '0;
                        end else if (ReqWrite && (ReqSize == SIZE_WORD)) begin
                            // Full-word store needs no read; go straight to WRITE.
                            state            <= WRITE;
                            write_enable_q   <= 1'b1;
                            mem_write_data_q <= ReqData;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // The only cycle in which MemReadData is consumed.
                    if (write_q) begin
                        state            <= WRITE;
                        write_enable_q   <= 1'b1;
                        mem_write_data_q <= merged_word;
                    end else begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= load_value;
                    end
                end
                WRITE: begin
                    state        <= RESP;
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ReqReady       = ready_q;
    assign RespValid      = resp_valid_q;
    assign RespError      = resp_error_q;
    assign RespData       = resp_data_q;
    assign MemAddress     = mem_address_q;
    assign MemWriteData   = mem_write_data_q;
    // Gated by Reset so a reset landing in WRITE never reaches the memory.
    assign MemWriteEnable = write_enable_q && !Reset;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit. A behavioural word memory preloaded
//   with word i = i*4 sits behind the main instance; a second instance with
//   alignment errors disabled reads a memory whose words equal their address.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [31:0] ReqAddress;
    logic [31:0] ReqData;
    logic        RespValid;
    logic        RespError;
    logic [31:0] RespData;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWriteEnable;
    logic [31:0] MemReadData;

    // Second instance, alignment errors disabled; shares request fields.
    logic        ReqValid2;
    logic        ReqReady2;
    logic        RespValid2;
    logic        RespError2;
    logic [31:0] RespData2;
    logic [31:0] MemAddress2;
    logic [31:0] MemWriteData2;
    logic        MemWriteEnable2;
    logic [31:0] MemReadData2;

    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    load_store_unit #(.ADDR_WIDTH(32), .ERROR_ON_MISALIGN(1'b1)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .ReqValid       (ReqValid),
        .ReqReady       (ReqReady),
        .ReqWrite       (ReqWrite),
        .ReqSize        (ReqSize),
        .ReqSigned      (ReqSigned),
        .ReqAddress     (ReqAddress),
        .ReqData        (ReqData),
        .RespValid      (RespValid),
        .RespError      (RespError),
        .RespData       (RespData),
        .MemAddress     (MemAddress),
        .MemWriteData   (MemWriteData),
        .MemWriteEnable (MemWriteEnable),
        .MemReadData    (MemReadData)
    );

    load_store_unit #(.ADDR_WIDTH(32), .ERROR_ON_MISALIGN(1'b0)) dut_noerr (
        .Clock          (Clock),
        .Reset          (Reset),
        .ReqValid       (ReqValid2),
        .ReqReady       (ReqReady2),
        .ReqWrite       (ReqWrite),
        .ReqSize        (ReqSize),
        .ReqSigned      (ReqSigned),
        .ReqAddress     (ReqAddress),
        .ReqData        (ReqData),
        .RespValid      (RespValid2),
        .RespError      (RespError2),
        .RespData       (RespData2),
        .MemAddress     (MemAddress2),
        .MemWriteData   (MemWriteData2),
        .MemWriteEnable (MemWriteEnable2),
        .MemReadData    (MemReadData2)
    );

    // Memory model: combinational read, write on rising edge.
    logic [31:0] mem [0:63];
    logic        mem_load;

    always @(posedge Clock) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i * 4);
        end else if (MemWriteEnable) begin
            mem[MemAddress[7:2]] <= MemWriteData;
        end
    end

    assign MemReadData  = mem[MemAddress[7:2]];
    assign MemReadData2 = {MemAddress2[31:2], 2'b00};

    // Results of the last transact() call; cycle numbers count from the
    // accept edge (1 = first cycle after it).
    int          r_cycle;
    logic [31:0] r_data;
    logic        r_err;
    int          w_count;
    int          w_cycle;
    logic [31:0] w_data;
    logic [31:0] w_addr;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ReqReady !== 1'b1 && n < 10) begin
            @(negedge Clock);
            n++;
        end
        if (ReqReady !== 1'b1) check("ready_timeout", 32'(ReqReady), 32'd1);
    endtask

    // Called on a falling edge: issues one request and follows it until the
    // response pulse (bounded), logging any memory writes on the way.
    task automatic transact(input logic wr, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] data);
        ReqWrite   = wr;
        ReqSize    = size;
        ReqSigned  = sgn;
        ReqAddress = addr;
        ReqData    = data;
        ReqValid   = 1'b1;
        wait_ready();
        r_cycle = 0;
        r_data  = '0;
        r_err   = 1'b0;
        w_count = 0;
        w_cycle = 0;
        w_data  = '0;
        w_addr  = '0;
        @(posedge Clock);
        for (int k = 1; k <= 8 && r_cycle == 0; k++) begin
            @(negedge Clock);
            ReqValid = 1'b0;
            if (MemWriteEnable) begin
                w_count++;
                w_cycle = k;
                w_data  = MemWriteData;
                w_addr  = MemAddress;
            end
            if (RespValid) begin
                r_cycle = k;
                r_data  = RespData;
                r_err   = RespError;
            end
        end
    endtask

    logic [31:0] ld_addr [5] = '{32'h20, 32'h23, 32'h23, 32'h22, 32'h22};
    logic [1:0]  ld_size [5] = '{SIZE_BYTE, SIZE_BYTE, SIZE_BYTE, SIZE_HALF, SIZE_HALF};
    logic        ld_sign [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ld_exp  [5] = '{32'h0000_0001, 32'hFFFF_FF80, 32'h0000_0080,
                                 32'hFFFF_80FF, 32'h0000_80FF};

    logic        err_wr   [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  err_size [3] = '{SIZE_WORD, SIZE_HALF, SIZE_ILLEGAL};
    logic [31:0] err_addr [3] = '{32'h06, 32'h13, 32'h00};

    initial begin
        Reset      = 1'b1;
        mem_load   = 1'b1;
        ReqValid   = 1'b0;
        ReqValid2  = 1'b0;
        ReqWrite   = 1'b0;
        ReqSize    = SIZE_WORD;
        ReqSigned  = 1'b0;
        ReqAddress = '0;
        ReqData    = '0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge Clock);
        check("rst_resp_valid", 32'(RespValid), 32'd0);
        check("rst_resp_error", 32'(RespError), 32'd0);
        check("rst_resp_data", RespData, 32'd0);
        check("rst_mem_address", MemAddress, 32'd0);
        check("rst_mem_wdata", MemWriteData, 32'd0);
        check("rst_mem_we", 32'(MemWriteEnable), 32'd0);
        check("rst_ready", 32'(ReqReady), 32'd0);
        mem_load = 1'b0;
        Reset    = 1'b0;
        @(negedge Clock);
        check("ready_after_reset", 32'(ReqReady), 32'd1);

        // ---------------- lw 0x14 ----------------
        transact(1'b0, SIZE_WORD, 1'b0, 32'h14, 32'h0);
        check("lw14_cycle", 32'(r_cycle), 32'd2);
        check("lw14_data", r_data, 32'h0000_0014);
        check("lw14_err", 32'(r_err), 32'd0);
        check("lw14_writes", 32'(w_count), 32'd0);
        @(negedge Clock);
        check("lw14_pulse_one_cycle", 32'(RespValid), 32'd0);

        // ---------------- sw 0x80FF7F01 to 0x20 ----------------
        transact(1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h80FF_7F01);
        check("sw_cycle", 32'(r_cycle), 32'd2);
        check("sw_err", 32'(r_err), 32'd0);
        check("sw_writes", 32'(w_count), 32'd1);
        check("sw_write_cycle", 32'(w_cycle), 32'd1);
        check("sw_write_data", w_data, 32'h80FF_7F01);
        check("sw_write_addr", w_addr, 32'h20);

        // ---------------- sub-word loads of that word ----------------
        for (int i = 0; i < 5; i++) begin
            transact(1'b0, ld_size[i], ld_sign[i], ld_addr[i], 32'h0);
            check($sformatf("load%0d_data", i), r_data, ld_exp[i]);
            check($sformatf("load%0d_cycle", i), 32'(r_cycle), 32'd2);
        end

        // ---------------- sb 0xAB to 0x25 ----------------
        transact(1'b1, SIZE_BYTE, 1'b0, 32'h25, 32'h0000_00AB);
        check("sb_writes", 32'(w_count), 32'd1);
        check("sb_write_cycle", 32'(w_cycle), 32'd2);
        check("sb_write_data", w_data, 32'h0000_AB24);
        check("sb_write_addr", w_addr, 32'h24);
        check("sb_cycle", 32'(r_cycle), 32'd3);
        transact(1'b0, SIZE_WORD, 1'b0, 32'h24, 32'h0);
        check("lw24_data", r_data, 32'h0000_AB24);

        // ---------------- error cases ----------------
        for (int i = 0; i < 3; i++) begin
            transact(err_wr[i], err_size[i], 1'b0, err_addr[i], 32'hDEAD_BEEF);
            check($sformatf("err%0d_cycle", i), 32'(r_cycle), 32'd1);
            check($sformatf("err%0d_flag", i), 32'(r_err), 32'd1);
            check($sformatf("err%0d_data", i), r_data, 32'd0);
            check($sformatf("err%0d_writes", i), 32'(w_count), 32'd0);
        end

        // ---------------- misalign tolerated: lw 0x06 ----------------
        begin
            int          c2 = 0;
            logic [31:0] d2 = '0;
            logic        e2 = 1'b1;
            @(negedge Clock);
            ReqWrite   = 1'b0;
            ReqSize    = SIZE_WORD;
            ReqSigned  = 1'b0;
            ReqAddress = 32'h06;
            ReqValid2  = 1'b1;
            @(posedge Clock);
            for (int k = 1; k <= 6 && c2 == 0; k++) begin
                @(negedge Clock);
                ReqValid2 = 1'b0;
                if (RespValid2) begin
                    c2 = k;
                    d2 = RespData2;
                    e2 = RespError2;
                end
            end
            check("noerr_lw06_cycle", 32'(c2), 32'd2);
            check("noerr_lw06_data", d2, 32'h0000_0004);
            check("noerr_lw06_err", 32'(e2), 32'd0);
            check("noerr_no_write", 32'(MemWriteEnable2), 32'd0);
        end

        // ---------------- reset during WRITE of sh 0x1234 to 0x30 ----------------
        begin
            logic resp_seen = 1'b0;
            ReqWrite   = 1'b1;
            ReqSize    = SIZE_HALF;
            ReqSigned  = 1'b0;
            ReqAddress = 32'h30;
            ReqData    = 32'h0000_1234;
            ReqValid   = 1'b1;
            wait_ready();
            @(posedge Clock);
            @(negedge Clock);          // ACCESS
            ReqValid = 1'b0;
            @(negedge Clock);          // WRITE
            check("sh30_we_in_write", 32'(MemWriteEnable), 32'd1);
            Reset = 1'b1;
            #1;
            check("sh30_we_gated", 32'(MemWriteEnable), 32'd0);
            @(negedge Clock);
            Reset = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge Clock);
                if (RespValid) resp_seen = 1'b1;
            end
            check("sh30_no_resp", 32'(resp_seen), 32'd0);
            check("sh30_ready_after", 32'(ReqReady), 32'd1);
            transact(1'b0, SIZE_WORD, 1'b0, 32'h30, 32'h0);
            check("lw30_data", r_data, 32'h0000_0030);
        end

        // ---------------- back-to-back with ReqValid held ----------------
        begin
            int          n_resp = 0;
            int          resp_k [2] = '{0, 0};
            logic [31:0] resp_d [2] = '{32'h0, 32'h0};
            logic        ready_after = 1'b0;
            ReqWrite   = 1'b0;
            ReqSize    = SIZE_WORD;
            ReqSigned  = 1'b0;
            ReqAddress = 32'h00;
            ReqValid   = 1'b1;
            wait_ready();
            @(posedge Clock);
            for (int k = 1; k <= 10 && n_resp < 2; k++) begin
                @(negedge Clock);
                ReqAddress = 32'h04;
                if (n_resp == 1 && k == resp_k[0] + 1) ready_after = ReqReady;
                if (RespValid) begin
                    resp_k[n_resp] = k;
                    resp_d[n_resp] = RespData;
                    n_resp++;
                end
            end
            ReqValid = 1'b0;
            check("b2b_first_cycle", 32'(resp_k[0]), 32'd2);
            check("b2b_first_data", resp_d[0], 32'h0000_0000);
            check("b2b_ready_after_first", 32'(ready_after), 32'd1);
            check("b2b_second_cycle", 32'(resp_k[1]), 32'd5);
            check("b2b_second_data", resp_d[1], 32'h0000_0004);
        end

        repeat (2) @(negedge Clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
